hpdcache_wrrarb: RTL and testbench

Parametrised N-way arbiter with a run-time selectable mode: fixed priority or weighted round-robin. Once a grant is issued it is held stable until the consumer accepts it. Optional per-requester starvation guard. It is used at HPDcache shared-resource ports where several request sources compete for one downstream channel, such as the miss/refill, write-buffer and uncached request paths.

---
 rtl/hpdcache_wrrarb.sv | 158 +++++++++++++++
 tb/tb_hpdcache_wrrarb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_wrrarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hpdcache_wrrarb                                              |
// | Description : N-way arbiter, fixed-priority or weighted round-robin mode,  |
// |               grant held until accepted. Optional starvation guard is      |
// |               compiled in with HPDCACHE_ARB_STARVE_GUARD_EN.               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hpdcache_wrrarb #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 2,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [N-1:0]                           req_i,
  input  logic                                   mode_i,
  input  logic [N*W-1:0]                         weight_i,
  input  logic                                   ready_i,
  output logic [N-1:0]                           gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   gnt_id_o
);

  localparam int unsigned c_id_w = (N > 1) ? $clog2(N) : 1;

  logic              r_wait;
  logic [N-1:0]      r_gnt;
  logic [c_id_w-1:0] r_gnt_id;
  logic [c_id_w-1:0] r_ptr;
  logic [W-1:0]      r_cnt;

  logic [W-1:0]      w_weight [N];
  logic [N-1:0]      w_cand;
  logic              w_found;
  logic [c_id_w-1:0] w_win;
  logic              w_accept;
  logic [c_id_w-1:0] w_next;
  logic [W-1:0]      w_wk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_weight
      assign w_weight[g] = weight_i[g*W +: W];
    end
  endgenerate

  assign w_accept = (|gnt_o) && ready_i;

`ifdef HPDCACHE_ARB_STARVE_GUARD_EN
  localparam int unsigned c_age_w = $clog2(STARVE_MAX + 1);

  logic [N-1:0] w_urgent;

  generate
    for (genvar g = 0; g < N; g++) begin : g_age
      logic [c_age_w-1:0] r_age;

      assign w_urgent[g] = req_i[g] && (r_age == c_age_w'(STARVE_MAX));

      // Age saturates at STARVE_MAX; a dropped request or an accept restarts it
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_age <= '0;
        end else if (!req_i[g] || (w_accept && gnt_o[g])) begin
          r_age <= '0;
        end else if (r_age != c_age_w'(STARVE_MAX)) begin
          r_age <= r_age + 1'b1;
        end
      end
    end
  endgenerate

  assign w_cand = (|w_urgent) ? w_urgent : req_i;
`else
  assign w_cand = req_i;
`endif

  // Scan origin is 0 in fixed mode and r_ptr in WRR mode, wrapping at N
  always_comb begin : arb_scan
    logic [c_id_w:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      if (mode_i) begin
        idx = {1'b0, r_ptr} + (c_id_w+1)'(i);
        if (idx >= (c_id_w+1)'(N)) begin
          idx = idx - (c_id_w+1)'(N);
        end
      end else begin
        idx = (c_id_w+1)'(i);
      end
      if (!w_found && w_cand[idx[c_id_w-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[c_id_w-1:0];
      end
    end
  end

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    if (r_wait) begin
      gnt_o    = r_gnt;
      gnt_id_o = r_gnt_id;
    end else if (w_found) begin
      gnt_o    = {{(N-1){1'b0}}, 1'b1} << w_win;
      gnt_id_o = w_win;
    end
  end

  assign w_next = (gnt_id_o == c_id_w'(N-1)) ? '0 : gnt_id_o + 1'b1;
  assign w_wk   = w_weight[gnt_id_o];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait   <= 1'b0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
    end else if ((|gnt_o) && !ready_i) begin
      r_wait   <= 1'b1;
      r_gnt    <= gnt_o;
      r_gnt_id <= gnt_id_o;
    end else if (w_accept) begin
      r_wait   <= 1'b0;
    end
  end

  // Weighted round-robin bookkeeping; fixed mode leaves pointer and credit alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept && mode_i) begin
      if (gnt_id_o == r_ptr) begin
        if (r_cnt >= w_wk) begin
          r_ptr <= w_next;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_wk == '0) begin
        r_ptr <= w_next;
        r_cnt <= '0;
      end else begin
        r_ptr <= gnt_id_o;
        r_cnt <= W'(1);
      end
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));

  a_gnt_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (r_wait && !ready_i) |=> $stable(gnt_o));

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_wrrarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hpdcache_wrrarb                                           |
// | Description : Directed self-checking bench for hpdcache_wrrarb (N=4, W=2). |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_hpdcache_wrrarb;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] req    = '0;
  logic       mode   = 1'b0;
  logic [7:0] weight = '0;
  logic       ready  = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hpdcache_wrrarb #(
    .N          (4),
    .W          (2),
    .STARVE_MAX (3)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .mode_i   (mode),
    .weight_i (weight),
    .ready_i  (ready),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // One arbitration cycle: inputs change at negedge, outputs settle 1 ns later
  task automatic drive(input logic m, input logic [3:0] r, input logic rd);
    @(negedge clk);
    mode  = m;
    req   = r;
    ready = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; ready = 1'b0; mode = 1'b0; weight = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL reset gnt: got %b want 0000", gnt); end
    total++;
    if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset gnt_id: got %0d want 0", gnt_id); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    logic [3:0] reqs [5] = '{4'b1010, 4'b1000, 4'b0110, 4'b0000, 4'b1111};
    logic [3:0] egnt [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0001};
    logic [1:0] eid  [5] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, reqs[i], 1'b1);
      total++;
      if (gnt !== egnt[i]) begin bad++; $display("FAIL fixed[%0d] gnt: got %b want %b", i, gnt, egnt[i]); end
      total++;
      if (gnt_id !== eid[i]) begin bad++; $display("FAIL fixed[%0d] gnt_id: got %0d want %0d", i, gnt_id, eid[i]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b0, 4'b1000, 1'b0);
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_first gnt: got %b want 1000", gnt); end
    drive(1'b0, 4'b0001, 1'b0);
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_keep gnt: got %b want 1000", gnt); end
    total++;
    if (gnt_id !== 2'd3) begin bad++; $display("FAIL hold_keep gnt_id: got %0d want 3", gnt_id); end
    drive(1'b1, 4'b0001, 1'b1);
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL hold_mode_change gnt: got %b want 1000", gnt); end
    drive(1'b0, 4'b0001, 1'b1);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_release gnt: got %b want 0001", gnt); end
  endtask

  task automatic test_wrr_weights();
    int exp_id [10] = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1};
    logic [3:0] e;
    do_reset();
    weight = 8'b00_00_10_00;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b1111, 1'b1);
      e = 4'b0001 << exp_id[i];
      total++;
      if (gnt !== e) begin bad++; $display("FAIL wrr_weights[%0d] gnt: got %b want %b", i, gnt, e); end
      total++;
      if (gnt_id !== 2'(exp_id[i])) begin bad++; $display("FAIL wrr_weights[%0d] gnt_id: got %0d want %0d", i, gnt_id, exp_id[i]); end
    end
  endtask

  task automatic test_wrr_skip_wrap();
    logic [3:0] reqs   [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b0011};
    int         exp_id [6] = '{0, 1, 2, 1, 2, 0};
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, reqs[i], 1'b1);
      e = 4'b0001 << exp_id[i];
      total++;
      if (gnt !== e) begin bad++; $display("FAIL wrr_skip[%0d] gnt: got %b want %b", i, gnt, e); end
    end
  endtask

  task automatic test_wrr_jump();
    logic [3:0] reqs   [3] = '{4'b0100, 4'b0111, 4'b0111};
    int         exp_id [3] = '{2, 2, 0};
    logic [3:0] e;
    do_reset();
    weight = 8'b00_01_00_00;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, reqs[i], 1'b1);
      e = 4'b0001 << exp_id[i];
      total++;
      if (gnt !== e) begin bad++; $display("FAIL wrr_jump[%0d] gnt: got %b want %b", i, gnt, e); end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive(1'b1, 4'b1111, 1'b1);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_hold_pre gnt: got %b want 0001", gnt); end
    drive(1'b1, 4'b0100, 1'b0);
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_hold_grant gnt: got %b want 0100", gnt); end
    drive(1'b1, 4'b0011, 1'b0);
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_hold_held gnt: got %b want 0100", gnt); end
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_hold_async gnt: got %b want 0001", gnt); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4'b1111, 1'b1);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_hold_restart gnt: got %b want 0001", gnt); end
  endtask

`ifdef HPDCACHE_ARB_STARVE_GUARD_EN
  task automatic test_starve();
    int exp_id [8] = '{0, 0, 0, 3, 0, 0, 0, 3};
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1001, 1'b1);
      e = 4'b0001 << exp_id[i];
      total++;
      if (gnt !== e) begin bad++; $display("FAIL starve[%0d] gnt: got %b want %b", i, gnt, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_hold();
    test_wrr_weights();
    test_wrr_skip_wrap();
    test_wrr_jump();
    test_reset_mid_hold();
`ifdef HPDCACHE_ARB_STARVE_GUARD_EN
    test_starve();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
